// File: rtl/fetch_redirect_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// squashes wrong-path words and feeds IF/ID through a one-entry skid buffer.
// Optional macro FETCH_REDIRECT_STATS_EN adds saturating redirect/killed counters.

module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_e,
    input  logic [31:0] branch_target,
    input  logic        jalr_e,
    input  logic [31:0] jalr_target,
    input  logic        jal_d,
    input  logic [31:0] jal_target,
    input  logic        stall_f,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_d,
    output logic [31:0] pc_d,
    output logic        inst_valid_d,
    output logic        flush_e
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] killed_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_f_r;
    logic [31:0] pc_f_nxt_s;
    logic [31:0] req_pc_r;
    logic [31:0] req_pc_nxt_s;
    logic        kill_r;
    logic        kill_nxt_s;

    logic [31:0] skid_inst_r;
    logic [31:0] skid_pc_r;
    logic        skid_ld_s;

    logic [31:0] inst_d_r;
    logic [31:0] pc_d_r;
    logic        inst_valid_d_r;
    logic [31:0] inst_d_nxt_s;
    logic [31:0] pc_d_nxt_s;
    logic        inst_valid_d_nxt_s;

    logic        redir_s;
    logic [31:0] target_s;
    logic        req_s;
    logic [31:0] addr_s;
    logic        deliver_s;
    logic [31:0] deliver_inst_s;
    logic [31:0] deliver_pc_s;

    // Redirect arbitration: EX branch beats EX jalr beats ID jal.
    always_comb begin
        redir_s = branch_e | jalr_e | jal_d;
        if (branch_e) begin
            target_s = branch_target;
        end else if (jalr_e) begin
            target_s = jalr_target;
        end else begin
            target_s = jal_target;
        end
    end

    // Fetch FSM next-state, memory request and delivery selection.
    always_comb begin
        state_nxt_s    = state_r;
        pc_f_nxt_s     = pc_f_r;
        req_pc_nxt_s   = req_pc_r;
        kill_nxt_s     = kill_r;
        skid_ld_s      = 1'b0;
        deliver_s      = 1'b0;
        deliver_inst_s = imem_rdata;
        deliver_pc_s   = req_pc_r;
        req_s          = 1'b0;
        addr_s         = pc_f_r;

        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_ISSUE;
                if (redir_s) begin
                    pc_f_nxt_s = target_s;
                end else begin
                    pc_f_nxt_s = pc_f_r;
                end
            end

            ST_ISSUE: begin
                req_s = !stall_f || redir_s;
                if (redir_s) begin
                    addr_s = target_s;
                end else begin
                    addr_s = pc_f_r;
                end
                if (req_s && imem_gnt) begin
                    state_nxt_s  = ST_WAIT;
                    req_pc_nxt_s = addr_s;
                    pc_f_nxt_s   = addr_s + 32'd4;
                    kill_nxt_s   = 1'b0;
                end else if (redir_s) begin
                    pc_f_nxt_s = target_s;
                end else begin
                    pc_f_nxt_s = pc_f_r;
                end
            end

            ST_WAIT: begin
                if (redir_s) begin
                    pc_f_nxt_s = target_s;
                end else begin
                    pc_f_nxt_s = pc_f_r;
                end
                if (imem_rvalid) begin
                    // A redirect in the return cycle kills the word just like an earlier one.
                    if (kill_r || redir_s) begin
                        state_nxt_s = ST_ISSUE;
                        kill_nxt_s  = 1'b0;
                    end else if (stall_f) begin
                        state_nxt_s = ST_HOLD;
                        skid_ld_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                        deliver_s   = 1'b1;
                    end
                end else if (redir_s) begin
                    kill_nxt_s = 1'b1;
                end else begin
                    kill_nxt_s = kill_r;
                end
            end

            ST_HOLD: begin
                if (redir_s) begin
                    pc_f_nxt_s  = target_s;
                    state_nxt_s = ST_ISSUE;
                end else if (!stall_f) begin
                    deliver_s      = 1'b1;
                    deliver_inst_s = skid_inst_r;
                    deliver_pc_s   = skid_pc_r;
                    state_nxt_s    = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end

            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // IF/ID register next values: delivery, redirect bubble, stall hold, else bubble.
    always_comb begin
        inst_d_nxt_s       = inst_d_r;
        pc_d_nxt_s         = pc_d_r;
        inst_valid_d_nxt_s = inst_valid_d_r;
        if (deliver_s) begin
            inst_d_nxt_s       = deliver_inst_s;
            pc_d_nxt_s         = deliver_pc_s;
            inst_valid_d_nxt_s = 1'b1;
        end else if (redir_s) begin
            inst_valid_d_nxt_s = 1'b0;
        end else if (stall_f) begin
            inst_valid_d_nxt_s = inst_valid_d_r;
        end else begin
            inst_valid_d_nxt_s = 1'b0;
        end
    end

    // FSM state, fetch PC, in-flight request PC and kill flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_BOOT;
            pc_f_r   <= RESET_PC;
            req_pc_r <= RESET_PC;
            kill_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_f_r   <= pc_f_nxt_s;
            req_pc_r <= req_pc_nxt_s;
            kill_r   <= kill_nxt_s;
        end
    end

    // Skid buffer captures a returned word while decode is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_inst_r <= NOP_INST;
            skid_pc_r   <= 32'h0000_0000;
        end else if (skid_ld_s) begin
            skid_inst_r <= imem_rdata;
            skid_pc_r   <= req_pc_r;
        end else begin
            skid_inst_r <= skid_inst_r;
            skid_pc_r   <= skid_pc_r;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_d_r       <= NOP_INST;
            pc_d_r         <= 32'h0000_0000;
            inst_valid_d_r <= 1'b0;
        end else begin
            inst_d_r       <= inst_d_nxt_s;
            pc_d_r         <= pc_d_nxt_s;
            inst_valid_d_r <= inst_valid_d_nxt_s;
        end
    end

    assign imem_req     = req_s;
    assign imem_addr    = addr_s;
    assign inst_d       = inst_d_r;
    assign pc_d         = pc_d_r;
    assign inst_valid_d = inst_valid_d_r;
    // rst_n gates flush_e so a redirect seen during reset cannot clear ID/EX.
    assign flush_e      = rst_n & (branch_e | jalr_e);

`ifdef FETCH_REDIRECT_STATS_EN
    logic        drop_s;
    logic [31:0] redirect_cnt_r;
    logic [31:0] killed_cnt_r;

    assign drop_s = (state_r == ST_WAIT) && imem_rvalid && (kill_r || redir_s);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_r <= 32'h0000_0000;
            killed_cnt_r   <= 32'h0000_0000;
        end else begin
            if (redir_s && (redirect_cnt_r != 32'hFFFF_FFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
            if (drop_s && (killed_cnt_r != 32'hFFFF_FFFF)) begin
                killed_cnt_r <= killed_cnt_r + 32'd1;
            end else begin
                killed_cnt_r <= killed_cnt_r;
            end
        end
    end

    assign redirect_cnt = redirect_cnt_r;
    assign killed_cnt   = killed_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized scoreboard bench for fetch_redirect_ctrl: a transaction-level fetch model
// predicts request addresses and the delivered instruction stream.

module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_e = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jalr_e = 1'b0;
    logic [31:0] jalr_target = 32'h0;
    logic        jal_d = 1'b0;
    logic [31:0] jal_target = 32'h0;
    logic        stall_f = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic        inst_valid_d;
    logic        flush_e;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] killed_cnt;
`endif

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .branch_e(branch_e), .branch_target(branch_target),
        .jalr_e(jalr_e), .jalr_target(jalr_target),
        .jal_d(jal_d), .jal_target(jal_target),
        .stall_f(stall_f),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_d(inst_d), .pc_d(pc_d), .inst_valid_d(inst_valid_d),
        .flush_e(flush_e)
`ifdef FETCH_REDIRECT_STATS_EN
        , .redirect_cnt(redirect_cnt), .killed_cnt(killed_cnt)
`endif
    );

    typedef struct {
        bit          req;
        bit          flush;
        bit          chk_addr;
        logic [31:0] addr;
    } cyc_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } del_t;

    cyc_t q_cyc[$];
    del_t q_del[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   active = 1'b0;
    bit   rel = 1'b0;

    // Transaction-level model state
    bit          m_boot = 1'b0;
    bit          m_out = 1'b0;
    bit          m_killed = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_fa = 32'h0;
    logic [31:0] m_fd = 32'h0;
    logic [31:0] m_pend_inst = 32'h0;
    logic [31:0] m_pend_pc = 32'h0;
    int          m_lat = 0;
    int          stale = 0;
    int unsigned m_redir_cnt = 0;
    int unsigned m_kill_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            r = 32'hFFFF_FFFC;
        end else begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    // Monitor: compares each cycle's request/flush and every instruction leaving ID.
    initial begin
        cyc_t c;
        del_t d;
        forever begin
            @(negedge clk);
            #3;
            if (active) begin
                if (q_cyc.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cyc_queue: no expectation at %0t", $time);
                end else begin
                    c = q_cyc.pop_front();
                    check("imem_req", {31'b0, imem_req}, {31'b0, c.req});
                    check("flush_e", {31'b0, flush_e}, {31'b0, c.flush});
                    if (c.chk_addr) begin
                        check("imem_addr", imem_addr, c.addr);
                    end
                end
                if (inst_valid_d && (!stall_f || branch_e || jalr_e || jal_d)) begin
                    if (q_del.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_delivery: got inst %h pc %h", inst_d, pc_d);
                    end else begin
                        d = q_del.pop_front();
                        check("inst_d", inst_d, d.inst);
                        check("pc_d", pc_d, d.pc);
                    end
                end
            end
        end
    end

    // One clock of randomized stimulus plus the reference-model update.
    task automatic step(input bit quiet);
        cyc_t        c;
        logic        redir;
        logic [31:0] tgt;
        logic        exp_req;
        logic        grant;
        @(negedge clk);
        #1;
        if (rel) begin
            rst_n  = 1'b1;
            rel    = 1'b0;
            m_boot = 1'b1;
        end
        active        = 1'b1;
        stall_f       = !quiet && ($urandom_range(0, 9) < 3);
        branch_e      = !quiet && ($urandom_range(0, 11) == 0);
        jalr_e        = !quiet && ($urandom_range(0, 11) == 0);
        jal_d         = !quiet && ($urandom_range(0, 11) == 0);
        branch_target = rand_tgt();
        jalr_target   = rand_tgt();
        jal_target    = rand_tgt();
        imem_gnt      = !quiet && ($urandom_range(0, 9) < 7);
        imem_rvalid   = 1'b0;
        imem_rdata    = $urandom;
        if (m_out) begin
            m_lat--;
            if (m_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = m_fd;
            end
        end else if (stale > 0) begin
            imem_rvalid = 1'b1;
            stale--;
        end
        #1;
        redir = branch_e | jalr_e | jal_d;
        tgt   = branch_e ? branch_target : (jalr_e ? jalr_target : jal_target);
        if (redir) m_redir_cnt++;
        exp_req    = !m_boot && !m_out && !m_pend && (!stall_f || redir);
        grant      = exp_req && imem_gnt;
        c.req      = exp_req;
        c.flush    = branch_e | jalr_e;
        c.chk_addr = grant;
        c.addr     = redir ? tgt : m_pc;
        q_cyc.push_back(c);
        // Any redirect between grant and arrival in ID makes the word wrong-path.
        if (m_pend) begin
            if (redir) begin
                m_pend = 1'b0;
            end else if (!stall_f) begin
                q_del.push_back('{inst: m_pend_inst, pc: m_pend_pc});
                m_pend = 1'b0;
            end
        end
        if (m_out && imem_rvalid) begin
            m_out = 1'b0;
            if (m_killed || redir) begin
                m_kill_cnt++;
            end else if (!stall_f) begin
                q_del.push_back('{inst: imem_rdata, pc: m_fa});
            end else begin
                m_pend      = 1'b1;
                m_pend_inst = imem_rdata;
                m_pend_pc   = m_fa;
            end
        end else if (m_out && redir) begin
            m_killed = 1'b1;
        end
        if (grant) begin
            m_out    = 1'b1;
            m_killed = 1'b0;
            m_fa     = c.addr;
            m_pc     = c.addr + 32'd4;
            m_lat    = $urandom_range(1, 3);
            m_fd     = $urandom;
        end else if (redir) begin
            m_pc = tgt;
        end
        m_boot = 1'b0;
    endtask

    // Assert reset (with a redirect pending), check reset values, arm release.
    task automatic do_reset(input bit with_stale);
        @(negedge clk);
        #1;
        active      = 1'b0;
        rst_n       = 1'b0;
        branch_e    = 1'b1;
        jalr_e      = 1'b0;
        jal_d       = 1'b0;
        stall_f     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check("rst_inst_valid_d", {31'b0, inst_valid_d}, 32'd0);
        check("rst_inst_d", inst_d, 32'h0000_0013);
        check("rst_pc_d", pc_d, 32'h0000_0000);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_flush_e", {31'b0, flush_e}, 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        check("rst_redirect_cnt", redirect_cnt, 32'd0);
        check("rst_killed_cnt", killed_cnt, 32'd0);
`endif
        @(negedge clk);
        #1;
        branch_e    = 1'b0;
        imem_rvalid = with_stale;
        m_out       = 1'b0;
        m_pend      = 1'b0;
        m_killed    = 1'b0;
        m_pc        = RESET_PC;
        m_redir_cnt = 0;
        m_kill_cnt  = 0;
        stale       = with_stale ? 2 : 0;
        q_cyc.delete();
        q_del.delete();
        rel         = 1'b1;
    endtask

    initial begin
        int guard;
        do_reset(1'b0);
        for (int i = 0; i < 1500; i++) step(1'b0);
        guard = 0;
        while (!m_out && guard < 100) begin
            step(1'b0);
            guard++;
        end
        if (!m_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_outstanding: no grant within 100 cycles");
        end
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        @(negedge clk);
        #1;
        active = 1'b0;
        #2;
        check("deliveries_drained", 32'(q_del.size()), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        check("redirect_cnt", redirect_cnt, m_redir_cnt);
        check("killed_cnt", killed_cnt, m_kill_cnt);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
